rr_req_grant_arbiter: RTL
=========================

// Module: rr_req_grant_arbiter
// PURPOSE
//  Round-robin arbiter that shares one resource among N requesters using a level req/gnt handshake.
//  Grants are registered: a request sampled at a posedge is answered one cycle later, matching
//  the non-overlapping (|=>) req->grant contract that the team's benches check.
//  Sits in front of any shared datapath port (bus master slot, memory port) and carries its own SVA checks.
// PARAMETERS
//  N         4           number of requesters (>=2)
//  MAX_HOLD  8           max consecutive cycles an owner keeps gnt while others wait (>=1)
//  IDW       $clog2(N)   width of gnt_id (derived, do not override)
// PORTS
//  clk        in   1     single clock, all logic on posedge
//  rst_n      in   1     asynchronous, active-low reset
//  arb_en     in   1     1: new grants allowed; 0: no new grants, current owner may finish
//  req        in   N     level request per requester, held until the requester is done
//  gnt        out  N     registered one-hot grant (all-zero when idle)
//  gnt_id     out  IDW   index of current owner (valid only when gnt_valid=1)
//  gnt_valid  out  1     registered, equals |gnt
// BEHAVIOUR
//  Reset (async assert, any state): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold_cnt=0, state=ARB_IDLE.
//  Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod N. On every new grant, ptr <= winner+1 mod N.
//  ARB_IDLE: if arb_en && |req at edge k -> gnt=onehot(winner) after edge k, hold_cnt=0, go ARB_GRANT.
//            Otherwise stay idle with gnt=0.
//  ARB_GRANT, owner o:
//   - req[o]=0 at edge: release. If arb_en && other requests exist, grant the next winner at the same edge
//     (zero idle cycles). Otherwise gnt=0 and go ARB_IDLE.
//   - req[o]=1 && hold_cnt==MAX_HOLD-1 && arb_en && others pending: preempt; grant the next winner at that edge.
//   - Otherwise keep gnt and increment hold_cnt. hold_cnt saturates at MAX_HOLD-1 when no one else is waiting.
//  arb_en=0 never removes a current grant. Release still clears gnt; preemption is suppressed.
//  The owner's own bit is ignored in the re-pick at release/preempt (ptr already points past it).
//  Simultaneous requests in one cycle resolve purely by ptr. No combinational path from req to gnt.
//  Latency: 1 cycle req->gnt from idle, 1 cycle release->gnt cleared or handed over.
//  Fairness: a continuously held req is granted within (N-1)*MAX_HOLD+1 cycles while arb_en=1.
//  Reset deasserted mid-grant: first grant afterwards goes to the lowest requesting index (ptr=0).
//  Embedded SVA (disable iff !rst_n):
//   - $onehot0(gnt)
//   - gnt[i] |-> $past(req[i])
//   - gnt_valid == |gnt
//   - req[i] && arb_en |-> ##[1:(N-1)*MAX_HOLD+1] gnt[i]
//   - grant held by i with req[i] high and no other req |=> gnt[i]
// STRUCTURE
//  Package arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e
//   - localparam defaults ARB_N_DEF=4, ARB_HOLD_DEF=8
//  Sub-module rr_priority_pick (combinational): in req[N], ptr[IDW], mask_id[IDW], mask_en; out win_id[IDW], win_vld.
//  Top module holds: state, ptr, hold_cnt ($clog2(MAX_HOLD)+1 bits), gnt/gnt_id/gnt_valid registers, and the SVA.
// TESTING (N=4, MAX_HOLD=8, 2-unit clock)
//  1. Reset, then req=4'b0001 from cycle 1 -> gnt=0001, gnt_id=0 from cycle 2; drop req -> gnt=0 the next cycle.
//  2. req=4'b1111 held -> gnt order 0001,0010,0100,1000,0001, each held exactly 8 cycles, no gap between owners.
//  3. Owner 2 drops req while req[3]=1 -> gnt 0100->1000 on one edge; gnt_valid stays 1.
//  4. arb_en=0 with req=4'b0011 from idle -> gnt stays 0; arb_en=1 -> gnt=0001 the next cycle.
//     With arb_en=0 during a grant, the owner holds for more than 8 cycles.
//  5. rst_n pulsed low asynchronously mid-grant (owner 3) -> gnt=0 immediately, before the next edge.
//     After release with req=1010 -> gnt=0010.
//  6. Single requester 1 held for 20 cycles -> gnt=0010 continuously with no preemption; all SVA pass in every test.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin request/grant arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF    = 4;
    localparam int ARB_HOLD_DEF = 8;

    // Longest number of cycles a continuously requesting port can wait for its grant.
    function automatic int arb_wait_bound(input int n, input int hold);
        return (n - 1) * hold + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: finds the first set request
// scanning ptr, ptr+1, ... modulo N, optionally ignoring one index.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter  int N   = ARB_N_DEF,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic [IDW-1:0] mask_id,
    input  logic           mask_en,
    output logic [IDW-1:0] win_id,
    output logic           win_vld
);

    logic [N-1:0]   masked;
    logic [IDW-1:0] cand;

    // Drop the masked index, then walk the requests starting at ptr and keep the first hit.
    always_comb begin
        masked = req;
        if (mask_en) begin
            masked[mask_id] = 1'b0;
        end
        cand    = '0;
        win_id  = '0;
        win_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (!win_vld && masked[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

endmodule

// File: rtl/rr_req_grant_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters over a level
// req/gnt handshake. Grants are registered, so a request seen at one edge is
// answered after that edge; an owner is preempted after MAX_HOLD cycles when
// others are waiting and new grants are enabled.
module rr_req_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = ARB_N_DEF,
    parameter  int MAX_HOLD = ARB_HOLD_DEF,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arb_en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam int                HCW       = $clog2(MAX_HOLD) + 1;
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0]    LAST_ID   = IDW'(N - 1);

    arb_state_e     state_q;
    arb_state_e     state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [HCW-1:0] hold_q;
    logic [HCW-1:0] hold_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic           gnt_valid_d;

    logic           take_new;
    logic           owner_req;
    logic           hold_full;
    logic           pick_mask_en;
    logic [IDW-1:0] win_id;
    logic           win_vld;

    assign owner_req    = req[gnt_id];
    assign hold_full    = (hold_q == HOLD_LAST);
    assign pick_mask_en = (state_q == ARB_GRANT);

    // While someone owns the grant their own bit is masked, so the pick only
    // reports a winner when another requester is actually pending.
    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .mask_id (gnt_id),
        .mask_en (pick_mask_en),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    // State register; async reset returns to idle from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decide between a fresh grant, keeping the owner, or going idle.
    always_comb begin
        state_d  = state_q;
        take_new = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (arb_en && win_vld) begin
                    take_new = 1'b1;
                    state_d  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_req) begin
                    if (arb_en && win_vld) begin
                        take_new = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (hold_full && arb_en && win_vld) begin
                    take_new = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Next values of the grant, pointer and hold counter for the chosen action.
    always_comb begin
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        if (take_new) begin
            gnt_d    = N'(1) << win_id;
            gnt_id_d = win_id;
            ptr_d    = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
            hold_d   = '0;
        end else if (state_d == ARB_IDLE) begin
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
        end else if (!hold_full) begin
            hold_d = hold_q + HCW'(1);
        end
        gnt_valid_d = |gnt_d;
    end

    // Registered grant outputs plus the rotation pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_gnt_valid : assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid == (|gnt));

    localparam int             WAIT_MAX = arb_wait_bound(N, MAX_HOLD);
    localparam int             WCW      = $clog2(WAIT_MAX + 1) + 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

    for (genvar i = 0; i < N; i++) begin : g_sva
        localparam logic [N-1:0] ONLY_I = N'(1) << i;

        logic [WCW-1:0] wait_q;

        // Count consecutive cycles requester i waits with arbitration enabled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_q <= '0;
            end else if (req[i] && arb_en && !gnt[i]) begin
                if (wait_q != '1) begin
                    wait_q <= wait_q + WCW'(1);
                end
            end else begin
                wait_q <= '0;
            end
        end

        a_gnt_had_req : assert property (@(posedge clk) disable iff (!rst_n)
            gnt[i] |-> $past(req[i]));

        a_fair : assert property (@(posedge clk) disable iff (!rst_n)
            wait_q <= WAIT_LIM);

        a_sole_keep : assert property (@(posedge clk) disable iff (!rst_n)
            (gnt[i] && req[i] && ((req & ~ONLY_I) == '0)) |=> gnt[i]);
    end

endmodule
